// File: rtl/axis2bram_interface.sv
// AXI-Stream to BRAM writer: stores one packet per transfer and queues its byte count in a depth FIFO.
// Optional `AXIS2BRAM_TKEEP_EN: byte enables and last-beat length follow TKEEP.
module axis2bram_interface #(
  parameter int unsigned AXIS_DATA_WIDTH  = 64,
  parameter int unsigned BRAM_ADDR_WIDTH  = 32,
  parameter int unsigned BRAM_DATA_WIDTH  = 32,
  parameter int unsigned BRAM_DATA_DEPTH  = 4,
  parameter int unsigned DEPTH_FIFO_DEPTH = 4
) (
  input  logic                         ACC_CLK,
  input  logic                         ARESETN,
  input  logic                         CTRL_ALLOW,
  output logic                         CTRL_FINISHED,
  output logic                         STATUS_OVERFLOW,
  input  logic [AXIS_DATA_WIDTH-1:0]   AXIS_TDATA,
  input  logic [AXIS_DATA_WIDTH/8-1:0] AXIS_TKEEP,
  input  logic                         AXIS_TVALID,
  input  logic                         AXIS_TLAST,
  output logic                         AXIS_TREADY,
  output logic [BRAM_ADDR_WIDTH-1:0]   BRAM_ADDR,
  output logic [BRAM_DATA_WIDTH-1:0]   BRAM_DOUT,
  output logic                         BRAM_EN,
  output logic [BRAM_DATA_WIDTH/8-1:0] BRAM_WE,
  output logic [31:0]                  DATA_DEPTH,
  input  logic                         DATA_DEPTH_READ,
  output logic                         DATA_DEPTH_EMPTY,
  output logic                         DATA_DEPTH_FULL
);

  localparam int unsigned NUM_BYTES   = BRAM_DATA_WIDTH / 8;
  localparam int unsigned DEPTH_BYTES = BRAM_DATA_DEPTH * NUM_BYTES;
  localparam int unsigned PTR_W       = (DEPTH_FIFO_DEPTH > 1) ? $clog2(DEPTH_FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e               state;
  logic                 allow_reg;
  logic [31:0]          current_address;

  logic [31:0]          fifo_mem [DEPTH_FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       count;

  logic                 beat;
  logic                 push;
  logic                 pop;
  logic [31:0]          push_depth;
  logic [31:0]          last_bytes;
  logic [NUM_BYTES-1:0] keep_mask;
  logic                 unused_inputs;

`ifdef AXIS2BRAM_TKEEP_EN
  function automatic logic [31:0] popcount(input logic [NUM_BYTES-1:0] v);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      c = c + 32'(v[i]);
    end
    return c;
  endfunction
`endif

  always_comb begin
`ifdef AXIS2BRAM_TKEEP_EN
    keep_mask  = AXIS_TKEEP[NUM_BYTES-1:0];
    last_bytes = popcount(keep_mask);
`else
    keep_mask  = '1;
    last_bytes = 32'(NUM_BYTES);
`endif
  end

  assign AXIS_TREADY = (state == StRun) || (state == StFlush);
  assign beat        = AXIS_TVALID && AXIS_TREADY;

  assign BRAM_EN   = beat && (state == StRun);
  assign BRAM_WE   = BRAM_EN ? keep_mask : '0;
  assign BRAM_ADDR = BRAM_ADDR_WIDTH'(current_address);
  assign BRAM_DOUT = AXIS_TDATA[BRAM_DATA_WIDTH-1:0];

  assign CTRL_FINISHED = (state == StDone);

  // An overflowed packet is recorded as exactly filling the BRAM.
  assign push       = beat && AXIS_TLAST && ((state == StRun) || (state == StFlush));
  assign push_depth = (state == StRun) ? current_address + last_bytes : 32'(DEPTH_BYTES);
  assign pop        = DATA_DEPTH_READ && !DATA_DEPTH_EMPTY;

  assign DATA_DEPTH       = fifo_mem[rd_ptr];
  assign DATA_DEPTH_EMPTY = (count == '0);
  assign DATA_DEPTH_FULL  = (count == (PTR_W + 1)'(DEPTH_FIFO_DEPTH));

  assign unused_inputs = ^{AXIS_TDATA, AXIS_TKEEP, current_address};

  always_ff @(posedge ACC_CLK) begin
    if (!ARESETN) begin
      state           <= StIdle;
      allow_reg       <= 1'b0;
      current_address <= '0;
      STATUS_OVERFLOW <= 1'b0;
    end else begin
      allow_reg <= CTRL_ALLOW;
      case (state)
        StIdle: begin
          if (allow_reg && CTRL_ALLOW && !DATA_DEPTH_FULL) begin
            state           <= StRun;
            current_address <= '0;
            STATUS_OVERFLOW <= 1'b0;
          end
        end
        StRun: begin
          if (beat) begin
            if (AXIS_TLAST) begin
              state <= StDone;
            end else if (current_address == 32'(DEPTH_BYTES - NUM_BYTES)) begin
              STATUS_OVERFLOW <= 1'b1;
              state           <= StFlush;
            end else begin
              current_address <= current_address + 32'(NUM_BYTES);
            end
          end
        end
        StFlush: begin
          if (beat && AXIS_TLAST) begin
            state <= StDone;
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge ACC_CLK) begin
    if (!ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push && !DATA_DEPTH_FULL) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push && !DATA_DEPTH_FULL, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge ACC_CLK) begin
    if (push && !DATA_DEPTH_FULL) begin
      fifo_mem[wr_ptr] <= push_depth;
    end
  end

endmodule

// File: tb/tb_axis2bram_interface.sv
// Directed bench for axis2bram_interface: cycle table for basic, backpressure, overflow and
// mid-packet reset, plus sequences for FIFO full, simultaneous push/pop and TKEEP handling.
module tb_axis2bram_interface;

  logic        ACC_CLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        CTRL_ALLOW = 1'b0;
  logic        CTRL_FINISHED;
  logic        STATUS_OVERFLOW;
  logic [63:0] AXIS_TDATA = '0;
  logic [7:0]  AXIS_TKEEP = 8'hFF;
  logic        AXIS_TVALID = 1'b0;
  logic        AXIS_TLAST = 1'b0;
  logic        AXIS_TREADY;
  logic [31:0] BRAM_ADDR;
  logic [31:0] BRAM_DOUT;
  logic        BRAM_EN;
  logic [3:0]  BRAM_WE;
  logic [31:0] DATA_DEPTH;
  logic        DATA_DEPTH_READ = 1'b0;
  logic        DATA_DEPTH_EMPTY;
  logic        DATA_DEPTH_FULL;

  always #5 ACC_CLK = ~ACC_CLK;

  axis2bram_interface dut (
    .ACC_CLK          (ACC_CLK),
    .ARESETN          (ARESETN),
    .CTRL_ALLOW       (CTRL_ALLOW),
    .CTRL_FINISHED    (CTRL_FINISHED),
    .STATUS_OVERFLOW  (STATUS_OVERFLOW),
    .AXIS_TDATA       (AXIS_TDATA),
    .AXIS_TKEEP       (AXIS_TKEEP),
    .AXIS_TVALID      (AXIS_TVALID),
    .AXIS_TLAST       (AXIS_TLAST),
    .AXIS_TREADY      (AXIS_TREADY),
    .BRAM_ADDR        (BRAM_ADDR),
    .BRAM_DOUT        (BRAM_DOUT),
    .BRAM_EN          (BRAM_EN),
    .BRAM_WE          (BRAM_WE),
    .DATA_DEPTH       (DATA_DEPTH),
    .DATA_DEPTH_READ  (DATA_DEPTH_READ),
    .DATA_DEPTH_EMPTY (DATA_DEPTH_EMPTY),
    .DATA_DEPTH_FULL  (DATA_DEPTH_FULL)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One record per clock cycle: inputs held for the cycle, outputs expected before its edge.
  typedef struct packed {
    logic       rstn, allow, valid, last, rd;
    logic [7:0] data;
    logic       rdy, en;
    logic [3:0] we;
    logic [7:0] addr;
    logic       fin, ovf, empty;
    logic [7:0] depth;
  } vec_t;

  function automatic vec_t mk(input int rstn, input int allow, input int valid, input int last,
                              input int rd, input int data, input int rdy, input int en,
                              input int we, input int addr, input int fin, input int ovf,
                              input int empty, input int depth);
    vec_t v;
    v.rstn  = rstn[0];
    v.allow = allow[0];
    v.valid = valid[0];
    v.last  = last[0];
    v.rd    = rd[0];
    v.data  = data[7:0];
    v.rdy   = rdy[0];
    v.en    = en[0];
    v.we    = we[3:0];
    v.addr  = addr[7:0];
    v.fin   = fin[0];
    v.ovf   = ovf[0];
    v.empty = empty[0];
    v.depth = depth[7:0];
    return v;
  endfunction

  task automatic do_reset();
    ARESETN         = 1'b0;
    CTRL_ALLOW      = 1'b0;
    AXIS_TVALID     = 1'b0;
    AXIS_TLAST      = 1'b0;
    DATA_DEPTH_READ = 1'b0;
    repeat (2) begin
      @(posedge ACC_CLK);
      #1;
    end
    ARESETN = 1'b1;
  endtask

  // Starts a packet, waits (bounded) for TREADY, then sends nbeats back-to-back beats.
  task automatic send_pkt(input string tag, input int nbeats, input logic [3:0] last_keep,
                          input logic rd_on_last);
    int         waited;
    logic [3:0] exp_we;
    waited     = 0;
    CTRL_ALLOW = 1'b1;
    @(negedge ACC_CLK);
    while (!AXIS_TREADY && waited < 20) begin
      @(posedge ACC_CLK);
      #1;
      @(negedge ACC_CLK);
      waited++;
    end
    chk($sformatf("%s start tready", tag), 32'(AXIS_TREADY), 32'd1);
    @(posedge ACC_CLK);
    #1;
    CTRL_ALLOW = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      AXIS_TVALID     = 1'b1;
      AXIS_TLAST      = (b == nbeats - 1);
      AXIS_TDATA      = {32'hCAFE_F00D, 32'(b + 8'hB0)};
      AXIS_TKEEP      = {4'hF, (b == nbeats - 1) ? last_keep : 4'hF};
      DATA_DEPTH_READ = (b == nbeats - 1) && rd_on_last;
`ifdef AXIS2BRAM_TKEEP_EN
      exp_we = (b == nbeats - 1) ? last_keep : 4'hF;
`else
      exp_we = 4'hF;
`endif
      @(negedge ACC_CLK);
      chk($sformatf("%s beat%0d en", tag, b), 32'(BRAM_EN), 32'd1);
      chk($sformatf("%s beat%0d we", tag, b), 32'(BRAM_WE), 32'(exp_we));
      chk($sformatf("%s beat%0d addr", tag, b), BRAM_ADDR, 32'(4 * b));
      @(posedge ACC_CLK);
      #1;
    end
    AXIS_TVALID     = 1'b0;
    AXIS_TLAST      = 1'b0;
    AXIS_TKEEP      = 8'hFF;
    DATA_DEPTH_READ = 1'b0;
    @(negedge ACC_CLK);
    chk($sformatf("%s finished", tag), 32'(CTRL_FINISHED), 32'd1);
    @(posedge ACC_CLK);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit, expected test completion");
    $fatal(1, "simulation time limit");
  end

  vec_t        vecs [37];
  logic [31:0] drain_exp [3];

  initial begin
    //               rst al vl la rd data  rdy en we  addr fin ovf emp depth
    vecs[0]  = mk(0, 0, 0, 0, 0, 'h00, 0, 0, 'h0, 'h00, 0, 0, 1, 0);
    vecs[1]  = mk(1, 1, 0, 0, 0, 'h00, 0, 0, 'h0, 'h00, 0, 0, 1, 0);
    vecs[2]  = mk(1, 1, 0, 0, 0, 'h00, 0, 0, 'h0, 'h00, 0, 0, 1, 0);
    vecs[3]  = mk(1, 1, 1, 0, 0, 'h11, 1, 1, 'hF, 'h00, 0, 0, 1, 0);
    vecs[4]  = mk(1, 1, 1, 0, 0, 'h22, 1, 1, 'hF, 'h04, 0, 0, 1, 0);
    vecs[5]  = mk(1, 1, 1, 1, 0, 'h33, 1, 1, 'hF, 'h08, 0, 0, 1, 0);
    vecs[6]  = mk(1, 0, 0, 0, 0, 'h00, 0, 0, 'h0, 'h08, 1, 0, 0, 12);
    vecs[7]  = mk(1, 1, 0, 0, 1, 'h00, 0, 0, 'h0, 'h08, 0, 0, 0, 12);
    vecs[8]  = mk(1, 1, 0, 0, 0, 'h00, 0, 0, 'h0, 'h08, 0, 0, 1, 0);
    // backpressure: TVALID 1,0,0,1,1
    vecs[9]  = mk(1, 0, 1, 0, 0, 'hA1, 1, 1, 'hF, 'h00, 0, 0, 1, 0);
    vecs[10] = mk(1, 0, 0, 0, 0, 'h00, 1, 0, 'h0, 'h04, 0, 0, 1, 0);
    vecs[11] = mk(1, 0, 0, 0, 0, 'h00, 1, 0, 'h0, 'h04, 0, 0, 1, 0);
    vecs[12] = mk(1, 0, 1, 0, 0, 'hA2, 1, 1, 'hF, 'h04, 0, 0, 1, 0);
    vecs[13] = mk(1, 0, 1, 1, 0, 'hA3, 1, 1, 'hF, 'h08, 0, 0, 1, 0);
    vecs[14] = mk(1, 0, 0, 0, 0, 'h00, 0, 0, 'h0, 'h08, 1, 0, 0, 12);
    vecs[15] = mk(1, 0, 0, 0, 1, 'h00, 0, 0, 'h0, 'h08, 0, 0, 0, 12);
    // reads while empty must be ignored
    vecs[16] = mk(1, 1, 0, 0, 1, 'h00, 0, 0, 'h0, 'h08, 0, 0, 1, 0);
    vecs[17] = mk(1, 1, 0, 0, 1, 'h00, 0, 0, 'h0, 'h08, 0, 0, 1, 0);
    // overflow: 6 beats into a 4-word BRAM
    vecs[18] = mk(1, 0, 1, 0, 0, 'h01, 1, 1, 'hF, 'h00, 0, 0, 1, 0);
    vecs[19] = mk(1, 0, 1, 0, 0, 'h02, 1, 1, 'hF, 'h04, 0, 0, 1, 0);
    vecs[20] = mk(1, 0, 1, 0, 0, 'h03, 1, 1, 'hF, 'h08, 0, 0, 1, 0);
    vecs[21] = mk(1, 0, 1, 0, 0, 'h04, 1, 1, 'hF, 'h0C, 0, 0, 1, 0);
    vecs[22] = mk(1, 0, 1, 0, 0, 'h05, 1, 0, 'h0, 'h0C, 0, 1, 1, 0);
    vecs[23] = mk(1, 0, 1, 1, 0, 'h06, 1, 0, 'h0, 'h0C, 0, 1, 1, 0);
    vecs[24] = mk(1, 0, 0, 0, 0, 'h00, 0, 0, 'h0, 'h0C, 1, 1, 0, 16);
    vecs[25] = mk(1, 1, 0, 0, 0, 'h00, 0, 0, 'h0, 'h0C, 0, 1, 0, 16);
    vecs[26] = mk(1, 1, 0, 0, 0, 'h00, 0, 0, 'h0, 'h0C, 0, 1, 0, 16);
    vecs[27] = mk(1, 0, 0, 0, 0, 'h00, 1, 0, 'h0, 'h00, 0, 0, 0, 16);
    // reset after the second of four beats
    vecs[28] = mk(1, 0, 1, 0, 0, 'h51, 1, 1, 'hF, 'h00, 0, 0, 0, 16);
    vecs[29] = mk(1, 0, 1, 0, 0, 'h52, 1, 1, 'hF, 'h04, 0, 0, 0, 16);
    vecs[30] = mk(0, 0, 1, 0, 0, 'h53, 1, 1, 'hF, 'h08, 0, 0, 0, 16);
    vecs[31] = mk(1, 0, 1, 0, 0, 'h54, 0, 0, 'h0, 'h00, 0, 0, 1, 0);
    vecs[32] = mk(1, 1, 0, 0, 0, 'h00, 0, 0, 'h0, 'h00, 0, 0, 1, 0);
    vecs[33] = mk(1, 1, 0, 0, 0, 'h00, 0, 0, 'h0, 'h00, 0, 0, 1, 0);
    vecs[34] = mk(1, 0, 1, 1, 0, 'h61, 1, 1, 'hF, 'h00, 0, 0, 1, 0);
    vecs[35] = mk(1, 0, 0, 0, 0, 'h00, 0, 0, 'h0, 'h00, 1, 0, 0, 4);
    vecs[36] = mk(1, 0, 0, 0, 0, 'h00, 0, 0, 'h0, 'h00, 0, 0, 0, 4);
    drain_exp = '{32'd12, 32'd16, 32'd4};

    do_reset();
    ARESETN = 1'b0;

    for (int i = 0; i < 37; i++) begin
      ARESETN         = vecs[i].rstn;
      CTRL_ALLOW      = vecs[i].allow;
      AXIS_TVALID     = vecs[i].valid;
      AXIS_TLAST      = vecs[i].last;
      DATA_DEPTH_READ = vecs[i].rd;
      AXIS_TDATA      = {32'hDEAD_BEEF, 24'h0, vecs[i].data};
      AXIS_TKEEP      = 8'hFF;
      @(negedge ACC_CLK);
      chk($sformatf("v%0d tready", i), 32'(AXIS_TREADY), 32'(vecs[i].rdy));
      chk($sformatf("v%0d bram_en", i), 32'(BRAM_EN), 32'(vecs[i].en));
      chk($sformatf("v%0d bram_we", i), 32'(BRAM_WE), 32'(vecs[i].we));
      chk($sformatf("v%0d bram_addr", i), BRAM_ADDR, 32'(vecs[i].addr));
      chk($sformatf("v%0d finished", i), 32'(CTRL_FINISHED), 32'(vecs[i].fin));
      chk($sformatf("v%0d overflow", i), 32'(STATUS_OVERFLOW), 32'(vecs[i].ovf));
      chk($sformatf("v%0d empty", i), 32'(DATA_DEPTH_EMPTY), 32'(vecs[i].empty));
      chk($sformatf("v%0d full", i), 32'(DATA_DEPTH_FULL), 32'd0);
      if (vecs[i].en) begin
        chk($sformatf("v%0d bram_dout", i), BRAM_DOUT, 32'(vecs[i].data));
      end
      if (!vecs[i].empty) begin
        chk($sformatf("v%0d depth", i), DATA_DEPTH, 32'(vecs[i].depth));
      end
      @(posedge ACC_CLK);
      #1;
    end

    // FIFO full: packets of 1..4 beats give depths 4, 8, 12, 16 (the 4-beat one ends exactly
    // in the last slot and must not flag overflow).
    do_reset();
    send_pkt("p1", 1, 4'hF, 1'b0);
    send_pkt("p2", 2, 4'hF, 1'b0);
    send_pkt("p3", 3, 4'hF, 1'b0);
    send_pkt("p4", 4, 4'hF, 1'b0);
    @(negedge ACC_CLK);
    chk("full after 4", 32'(DATA_DEPTH_FULL), 32'd1);
    chk("empty after 4", 32'(DATA_DEPTH_EMPTY), 32'd0);
    chk("head after 4", DATA_DEPTH, 32'd4);
    chk("no overflow on last-slot tlast", 32'(STATUS_OVERFLOW), 32'd0);
    @(posedge ACC_CLK);
    #1;
    CTRL_ALLOW = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge ACC_CLK);
      chk($sformatf("full blocks start c%0d", k), 32'(AXIS_TREADY), 32'd0);
      @(posedge ACC_CLK);
      #1;
    end
    DATA_DEPTH_READ = 1'b1;
    @(negedge ACC_CLK);
    chk("tready during pop", 32'(AXIS_TREADY), 32'd0);
    @(posedge ACC_CLK);
    #1;
    DATA_DEPTH_READ = 1'b0;
    @(negedge ACC_CLK);
    chk("full after pop", 32'(DATA_DEPTH_FULL), 32'd0);
    chk("head after pop", DATA_DEPTH, 32'd8);
    @(posedge ACC_CLK);
    #1;
    // Fifth packet pops on its TLAST beat: push and pop in the same cycle.
    send_pkt("p5", 1, 4'hF, 1'b1);
    @(negedge ACC_CLK);
    chk("full after push+pop", 32'(DATA_DEPTH_FULL), 32'd0);
    chk("head after push+pop", DATA_DEPTH, 32'd12);
    @(posedge ACC_CLK);
    #1;
    for (int k = 0; k < 3; k++) begin
      DATA_DEPTH_READ = 1'b1;
      @(negedge ACC_CLK);
      chk($sformatf("drain %0d", k), DATA_DEPTH, drain_exp[k]);
      @(posedge ACC_CLK);
      #1;
    end
    DATA_DEPTH_READ = 1'b0;
    @(negedge ACC_CLK);
    chk("empty after drain", 32'(DATA_DEPTH_EMPTY), 32'd1);
    @(posedge ACC_CLK);
    #1;

    // Partial last beat: TKEEP=0x3 counts only when the TKEEP feature is built in.
    do_reset();
    send_pkt("tk", 3, 4'h3, 1'b0);
    @(negedge ACC_CLK);
    chk("tk empty", 32'(DATA_DEPTH_EMPTY), 32'd0);
`ifdef AXIS2BRAM_TKEEP_EN
    chk("tk depth", DATA_DEPTH, 32'd10);
`else
    chk("tk depth", DATA_DEPTH, 32'd12);
`endif
    @(posedge ACC_CLK);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
